// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit FIFO plus sequencer that feeds one byte per frame to a UART transmitter.
// Strobe appears two cycles after a push into an empty FIFO; pushes while full are dropped.
module uart_tx_fifo_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [DATAWIDTH-1:0]   wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  input  logic                   tx_done_i,
  output logic                   tx_start_o,
  output logic [DATAWIDTH-1:0]   tx_data_o,
  output logic                   busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 overflow_q;
  logic [DATAWIDTH-1:0] tx_data_q;
  logic                 push;
  logic                 pop;

  // Flags come from the registered count only, so a same-cycle pop never frees a slot.
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign push       = wr_en_i && !full_o;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= wr_en_i && full_o;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        tx_data_q <= mem[rd_ptr_q];
      end
    end
  end

  // WAIT_ACK absorbs the transmitter's registered done flag lagging the strobe.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_o && tx_done_i) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START:     state_d = WAIT_ACK;
      WAIT_ACK:  if (!tx_done_i) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign tx_start_o = (state_q == START);
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl with a simple transmitter model on tx_done_i.
module tb_uart_tx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       full_o;
  logic       empty_o;
  logic [4:0] count_o;
  logic       overflow_o;
  logic       tx_done_i;
  logic       tx_start_o;
  logic [7:0] tx_data_o;
  logic       busy_o;

  int checks = 0;
  int failures = 0;

  logic       model_done = 1'b1;
  logic       force_low = 1'b0;
  int         frame_len = 160;
  int         starts = 0;
  int         bad_starts = 0;
  logic [7:0] captured [$];

  assign tx_done_i = model_done && !force_low;

  always #5 clk = ~clk;

  uart_tx_fifo_ctrl #(.DATAWIDTH(8), .DEPTH(16)) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_data_i  (wr_data_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .tx_done_i  (tx_done_i),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .busy_o     (busy_o)
  );

  // Transmitter model: flag drops 2 cycles after the strobe, rises frame_len cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start_o && !rst_i) begin
        captured.push_back(tx_data_o);
        starts++;
        if (!tx_done_i) bad_starts++;
        repeat (2) @(negedge clk);
        model_done = 1'b0;
        repeat (frame_len) @(negedge clk);
        model_done = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en_i   = 1'b1;
    wr_data_i = b;
    @(negedge clk);
    wr_en_i   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (!(!busy_o && empty_o && model_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic clear_log();
    captured.delete();
    starts = 0;
    bad_starts = 0;
  endtask

  initial begin
    int errs;
    int n;
    int held;

    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_start", 32'(tx_start_o), 32'd0);
    chk("rst_data", 32'(tx_data_o), 32'h00);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Single byte: count 1 after push edge, strobe after the following edge
    frame_len = 160;
    clear_log();
    push(8'hA5);
    chk("single_count1", 32'(count_o), 32'd1);
    chk("single_nostart_yet", 32'(tx_start_o), 32'd0);
    @(negedge clk);
    chk("single_start", 32'(tx_start_o), 32'd1);
    chk("single_data", 32'(tx_data_o), 32'hA5);
    chk("single_count0", 32'(count_o), 32'd0);
    chk("single_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("single_start_1cyc", 32'(tx_start_o), 32'd0);
    chk("single_data_held", 32'(tx_data_o), 32'hA5);
    wait_idle(400, "single_idle_timeout");
    repeat (10) @(negedge clk);
    chk("single_busy_end", 32'(busy_o), 32'd0);
    chk("single_starts", 32'(starts), 32'd1);
    chk("single_data_hold_idle", 32'(tx_data_o), 32'hA5);

    // Burst order
    frame_len = 20;
    clear_log();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_idle(500, "burst_timeout");
    chk("burst_starts", 32'(starts), 32'd3);
    chk("burst_b0", 32'(captured.size() > 0 ? captured[0] : 8'hXX), 32'h01);
    chk("burst_b1", 32'(captured.size() > 1 ? captured[1] : 8'hXX), 32'h02);
    chk("burst_b2", 32'(captured.size() > 2 ? captured[2] : 8'hXX), 32'h03);
    chk("burst_no_start_while_low", 32'(bad_starts), 32'd0);

    // Full / overflow with transmitter held busy
    clear_log();
    force_low = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    chk("full_flag", 32'(full_o), 32'd1);
    chk("full_count", 32'(count_o), 32'd16);
    chk("full_ovf_before", 32'(overflow_o), 32'd0);
    push(8'hEE);
    chk("ovf_pulse", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd16);
    @(negedge clk);
    chk("ovf_pulse_end", 32'(overflow_o), 32'd0);
    chk("full_no_start", 32'(starts), 32'd0);
    force_low = 1'b0;
    wait_idle(2000, "full_drain_timeout");
    chk("full_starts", 32'(starts), 32'd16);
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (i >= captured.size() || captured[i] !== 8'(8'h10 + i)) errs++;
    chk("full_order", 32'(errs), 32'd0);
    chk("full_empty_after", 32'(empty_o), 32'd1);

    // Pointer wrap: two batches of 10
    frame_len = 4;
    clear_log();
    for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
    wait_idle(500, "wrap1_timeout");
    for (int i = 0; i < 10; i++) push(8'(8'h50 + i));
    wait_idle(500, "wrap2_timeout");
    chk("wrap_starts", 32'(starts), 32'd20);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i >= captured.size() || captured[i] !== 8'(8'h30 + i)) errs++;
      if (i + 10 >= captured.size() || captured[i + 10] !== 8'(8'h50 + i)) errs++;
    end
    chk("wrap_order", 32'(errs), 32'd0);
    chk("wrap_no_start_while_low", 32'(bad_starts), 32'd0);

    // Reset mid-frame with 5 bytes queued
    frame_len = 200;
    clear_log();
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    n = 0;
    while (tx_done_i && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_wait_done", 32'(n < 50), 32'd1);
    chk("midrst_queued", 32'(count_o), 32'd5);
    chk("midrst_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("midrst_count", 32'(count_o), 32'd0);
    chk("midrst_idle", 32'(busy_o), 32'd0);
    chk("midrst_empty", 32'(empty_o), 32'd1);
    held = starts;
    n = 0;
    while (!model_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("midrst_no_restart", 32'(starts), 32'(held));
    frame_len = 4;
    push(8'h77);
    wait_idle(100, "midrst_new_timeout");
    chk("midrst_new_starts", 32'(starts), 32'(held + 1));
    chk("midrst_new_data", 32'(captured.size() > 0 ? captured[captured.size() - 1] : 8'hXX), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- Transmit-side buffer and sequencer that sits directly upstream of the UART transmitter.
- Host logic pushes bytes into an internal FIFO at any rate.
- The controller pops one byte at a time and issues a single-cycle start strobe with the data to the transmitter.
- It then tracks the transmitter's done/idle flag through each frame before issuing the next byte.

Parameters:
- DATAWIDTH, 8, width of each data word; must match the transmitter's data width.
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- wr_en_i  input  1  push request from the host.
- wr_data_i  input  DATAWIDTH  push data.
- full_o  output  1  FIFO holds DEPTH entries.
- empty_o  output  1  FIFO holds 0 entries.
- count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow_o  output  1  one-cycle pulse when a push is dropped.
- tx_done_i  input  1  transmitter done/idle flag; high while the transmitter is idle, low during a frame.
- tx_start_o  output  1  one-cycle start strobe to the transmitter.
- tx_data_o  output  DATAWIDTH  byte presented to the transmitter.
- busy_o  output  1  high while a frame is outstanding (any state other than IDLE).

Behaviour:
- Reset (rst_i high at a rising edge):
  - FIFO pointers and count go to 0, state goes to IDLE.
  - Outputs: empty_o=1, full_o=0, count_o=0, overflow_o=0, tx_start_o=0, tx_data_o=0, busy_o=0.
  - Reset mid-frame discards FIFO contents and the outstanding frame. The controller does not wait for tx_done_i.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo DEPTH, plus an occupancy counter.
  - Push is accepted when wr_en_i=1 and full_o=0. Data is written at the write pointer, which then increments.
  - A push while full_o=1 is dropped, and overflow_o pulses high the next cycle. This holds even if a pop happens in the same cycle, because full is evaluated on the registered count.
  - A pop and a push in the same cycle leave count unchanged; both pointers advance.
  - There is no bypass. A byte pushed into an empty FIFO becomes visible to the sequencer the cycle after the push.
  - full_o, empty_o and count_o are registered or derived from the registered count, and are valid the cycle after the push/pop edge.
- Sequencer FSM, states IDLE, START, WAIT_ACK, WAIT_DONE:
  - IDLE: if empty_o=0 and tx_done_i=1, pop the head into the tx_data_o register, drive tx_start_o=1 for the next cycle, and go to START. Otherwise stay in IDLE.
  - START: tx_start_o=1 for exactly this one cycle, then go to WAIT_ACK; tx_start_o returns to 0.
  - WAIT_ACK: wait for tx_done_i=0, meaning the transmitter has left its idle state, then go to WAIT_DONE. The transmitter's flag is registered, so it may remain high for 1–2 cycles after the strobe; this state masks that.
  - WAIT_DONE: wait for tx_done_i=1, meaning the stop bit has completed, then go to IDLE.
- tx_data_o is held stable from the pop until the next pop.
- Back-to-back frames: from tx_done_i rising in WAIT_DONE to the next tx_start_o is 2 cycles (WAIT_DONE→IDLE, then IDLE→START).
- Latency: push at edge N with the FIFO empty, sequencer in IDLE and tx_done_i=1:
  - count_o=1 after edge N.
  - Pop and tx_start_o=1 after edge N+1.
  - count_o returns to 0 after edge N+1.
- Simultaneous host push and sequencer pop are both honoured, subject to the full rule above.
- Illegal state encoding returns to IDLE.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles -> empty_o=1, count_o=0, tx_start_o=0, tx_data_o=0x00, busy_o=0.
- Single byte: push 0xA5 with tx_done_i=1 -> tx_start_o high for exactly 1 cycle, 2 cycles after the push, with tx_data_o=0xA5. A model drops tx_done_i 2 cycles later and raises it 160 cycles later -> busy_o returns to 0, no second start.
- Burst order: push 0x01,0x02,0x03 on consecutive cycles -> three start strobes carrying 0x01,0x02,0x03 in order. Each strobe is separated by a full tx_done_i low period, and no strobe occurs while tx_done_i=0.
- Full/overflow (DEPTH=16, tx_done_i held 0): push 17 bytes -> full_o=1 after the 16th and count_o=16; the 17th is dropped and overflow_o pulses 1 cycle. Release tx_done_i -> exactly 16 bytes are transmitted.
- Pointer wrap: push 10, drain 10, push 10 -> the second batch is output intact and in order.
- Reset mid-frame: assert rst_i in WAIT_DONE with 5 bytes queued -> the next cycle shows count_o=0 and state IDLE. No tx_start_o occurs afterwards until a new push.
